sd_adc_decim: RTL and testbench
===============================

Name: sd_adc_decim

Overview:
- Per-channel front end for the six sigma-delta ADC pins (sd0p..sd5p).
- Functions:
  - synchronises the comparator bit;
  - drives the pcm feedback pin that closes the external RC loop;
  - decimates the bitstream with a sinc3 CIC filter into OUT_W-bit samples.
- Sits between the ADC pins and the trigger/trace-capture logic, which consumes sample/sample_valid. The top level instantiates it six times.

Parameters:
- DECIM_LOG2, 8, log2 of the decimation ratio R (R=256). Legal range 4..10.
- OUT_W, 10, output sample width. Must satisfy 3*DECIM_LOG2 >= OUT_W.

Ports:
- clk64M  in  1  system clock, 64 MHz
- reset_n  in  1  reset, synchronous, active-low
- sd  in  1  asynchronous comparator bit from the ADC pin
- enable  in  1  channel run enable (register-controlled)
- pcm  out  1  feedback bit to the ADC RC network
- sample  out  OUT_W  latest decimated sample, unsigned, midscale = 2^(OUT_W-1)
- sample_valid  out  1  one-clk strobe when sample updates
- overrange  out  1  sticky; set when a sample saturated; cleared by reset or by enable low

Behaviour:
- Reset: one clock, clk64M. Reset is synchronous and active-low (reset_n). While reset_n=0 at a clock edge:
  - all state clears;
  - pcm=0, sample=0, sample_valid=0, overrange=0.
- Input sync: 2-flop synchroniser on sd gives sd_s. pcm is a registered copy of sd_s, so sd to pcm latency is 3 clocks.
  - When enable=0, pcm is forced to 0.
- Datapath width: internal width W = 3*DECIM_LOG2+1. All integrators and combs use modulo-2^W arithmetic; wrap-around is intended and correct for CIC.
- Integrators: three cascaded accumulators, updated every enabled cycle. Input is sd_s zero-extended to W bits.
- Decimation counter dc:
  - counts 0..R-1 on enabled cycles;
  - starts at 0 on the first enabled cycle (cycle 0).
- Combs: on the cycle dc==R-1, the three cascaded differentiators (delay 1 at decimated rate) register the integrator-3 value.
- Output stage: on the cycle after the comb update:
  - y = comb3 >> (3*DECIM_LOG2 - OUT_W);
  - if y > 2^OUT_W-1, then sample = 2^OUT_W-1 and overrange is set; otherwise sample = y[OUT_W-1:0];
  - sample_valid pulses for exactly 1 clk.
  - Consequence: decimation N completes at cycle N*R-1 and its strobe appears at cycle N*R.
- Warm-up: the strobes for decimations 1..3 (filter fill) are suppressed, and sample is not updated for them. The first sample_valid is at cycle 4R; thereafter one strobe every R cycles.
- Enable low (any cycle):
  - clears integrators, combs, dc, warm-up count and overrange;
  - sample holds its last value;
  - sample_valid=0.
  - Re-enable restarts the warm-up.
- Enable and reset are evaluated the same cycle; reset wins.
- Reset mid-decimation discards the partial window. No strobe is issued for it.
- Gain: the sum of ones over the window maps to full scale 2^(3*DECIM_LOG2). An all-ones input therefore saturates by exactly 1 LSB, which is the normal overrange case.

Decomposition:
- Shared package etarget_adc_pkg holds:
  - constants ADC_DECIM_LOG2 and ADC_OUT_W;
  - localparam function cic_width(log2r) returning 3*log2r+1;
  - ADC_MIDSCALE.
- One natural sub-module, cic_sinc3: integrators, decimation counter, combs and a done strobe.
- The synchroniser, pcm register, scaling/saturation and warm-up logic stay in sd_adc_decim.

Test Plan:
- sd held 0, enable=1 from reset release: first sample_valid at cycle 4*256=1024 after the first enabled cycle, sample=0; strobes then every 256 cycles; overrange=0.
- sd held 1: sample=1023 and overrange=1 on every strobe; pcm=1 three clocks after sd rises.
- sd alternating 0/1 each clock: settled samples exactly 512.
- sd repeating pattern 1,0,0,0: settled samples exactly 256.
- Enable dropped for 10 cycles at dc=100 then raised: no strobe during the gap; sample holds its prior value; overrange cleared; next strobe exactly 1024 cycles after re-enable.
- reset_n low for 1 cycle mid-window with sd=1: all outputs 0 the next cycle; first new strobe 1024 cycles after reset release.

Source files
------------

// File: rtl/etarget_adc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : etarget_adc_pkg                                              |
// | Purpose : Shared constants and helpers for the sigma-delta ADC front   |
// |           end (decimation ratio, output width, CIC datapath width).    |
// | Ports   : none (package)                                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package etarget_adc_pkg;

  // log2 of the decimation ratio (R = 256) and the output sample width.
  localparam int ADC_DECIM_LOG2 = 8;
  localparam int ADC_OUT_W      = 10;

  // Internal CIC width: three stages of log2(R) growth plus one bit so that
  // a full-scale window (exactly R^3) is still representable.
  function automatic int cic_width(input int log2r);
    return 3 * log2r + 1;
  endfunction

  // Unsigned output code corresponding to a 50 % ones density.
  localparam int ADC_MIDSCALE = 1 << (ADC_OUT_W - 1);

endpackage : etarget_adc_pkg
`default_nettype wire

// File: rtl/sd_adc_decim_cic_sinc3.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : cic_sinc3                                                    |
// | Purpose : Third-order CIC decimator (three integrators, decimation     |
// |           counter, three combs) for a 1-bit input stream.              |
// | Ports   : clk_i   - clock                                              |
// |           rst_ni  - synchronous active-low reset                       |
// |           en_i    - run enable; low clears all filter state            |
// |           x_i     - 1-bit input sample                                 |
// |           comb_o  - latest comb-3 output (modulo 2^W)                  |
// |           done_o  - high for one cycle when comb_o has just updated    |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module cic_sinc3
  import etarget_adc_pkg::*;
#(
  parameter int DECIM_LOG2 = ADC_DECIM_LOG2,
  parameter int W          = cic_width(DECIM_LOG2)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         x_i,
  output logic [W-1:0] comb_o,
  output logic         done_o
);

  logic [W-1:0]          int1_q, int2_q, int3_q;
  logic [W-1:0]          int1_d, int2_d, int3_d;
  // Previous decimated input of each comb stage (the z^-1 of the comb).
  logic [W-1:0]          dly1_q, dly2_q, dly3_q;
  logic [W-1:0]          comb1_d, comb2_d, comb3_d;
  logic [W-1:0]          comb3_q;
  logic [DECIM_LOG2-1:0] dc_q;
  logic                  done_q;
  logic                  last_d;

  localparam logic [DECIM_LOG2-1:0] c_DC_ONE = {{(DECIM_LOG2-1){1'b0}}, 1'b1};

  // Integrators are chained combinationally so that the value captured on
  // the last cycle of a window already includes that cycle's input; window
  // N therefore covers exactly cycles (N-1)*R .. N*R-1. All arithmetic is
  // modulo 2^W, the wrap-around cancels in the combs.
  always_comb begin
    int1_d  = int1_q + {{(W-1){1'b0}}, x_i};
    int2_d  = int2_q + int1_d;
    int3_d  = int3_q + int2_d;
    comb1_d = int3_d  - dly1_q;
    comb2_d = comb1_d - dly2_q;
    comb3_d = comb2_d - dly3_q;
    last_d  = &dc_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || !en_i) begin
      int1_q  <= '0;
      int2_q  <= '0;
      int3_q  <= '0;
      dly1_q  <= '0;
      dly2_q  <= '0;
      dly3_q  <= '0;
      comb3_q <= '0;
      dc_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      int1_q <= int1_d;
      int2_q <= int2_d;
      int3_q <= int3_d;
      // R is a power of two, so the counter wraps to 0 on its own.
      dc_q   <= dc_q + c_DC_ONE;
      done_q <= last_d;
      if (last_d) begin
        dly1_q  <= int3_d;
        dly2_q  <= comb1_d;
        dly3_q  <= comb2_d;
        comb3_q <= comb3_d;
      end
    end
  end

  assign comb_o = comb3_q;
  assign done_o = done_q;

endmodule : cic_sinc3
`default_nettype wire

// File: rtl/sd_adc_decim.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : sd_adc_decim                                                 |
// | Purpose : One sigma-delta ADC channel: comparator synchroniser, pcm    |
// |           feedback register, sinc3 decimation, output scaling with     |
// |           saturation, and filter warm-up suppression.                  |
// | Ports   : clk64M       - 64 MHz system clock                           |
// |           reset_n      - synchronous active-low reset                  |
// |           sd           - asynchronous comparator bit from the pin      |
// |           enable       - channel run enable                            |
// |           pcm          - feedback bit to the external RC network       |
// |           sample       - latest decimated sample (unsigned)            |
// |           sample_valid - one-clock strobe when sample updates          |
// |           overrange    - sticky saturation flag                        |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module sd_adc_decim
  import etarget_adc_pkg::*;
#(
  // DECIM_LOG2 legal range 4..10; OUT_W must not exceed 3*DECIM_LOG2.
  parameter int DECIM_LOG2 = ADC_DECIM_LOG2,
  parameter int OUT_W      = ADC_OUT_W
) (
  input  logic             clk64M,
  input  logic             reset_n,
  input  logic             sd,
  input  logic             enable,
  output logic             pcm,
  output logic [OUT_W-1:0] sample,
  output logic             sample_valid,
  output logic             overrange
);

  localparam int c_W     = cic_width(DECIM_LOG2);
  localparam int c_SHIFT = 3 * DECIM_LOG2 - OUT_W;
  // Decimations 1..3 only fill the filter; the fourth is the first output.
  localparam logic [1:0] c_WARM_DONE = 2'd3;

  logic             sync1_q, sync2_q;
  logic             pcm_q;
  logic [OUT_W-1:0] sample_q;
  logic             valid_q;
  logic             ovr_q;
  logic [1:0]       warm_q;

  logic [c_W-1:0]   comb;
  logic             cic_done;
  logic [c_W-1:0]   scaled;
  logic             sat;

  cic_sinc3 #(
    .DECIM_LOG2 (DECIM_LOG2),
    .W          (c_W)
  ) u_cic (
    .clk_i  (clk64M),
    .rst_ni (reset_n),
    .en_i   (enable),
    .x_i    (sync2_q),
    .comb_o (comb),
    .done_o (cic_done)
  );

  // Full-scale window (R^3 = 2^(3*DECIM_LOG2)) maps to 2^OUT_W, one code
  // above the largest output, so any bit above OUT_W-1 means saturation.
  assign scaled = comb >> c_SHIFT;
  assign sat    = |scaled[c_W-1:OUT_W];

  always_ff @(posedge clk64M) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      pcm_q    <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
      warm_q   <= '0;
    end else begin
      sync1_q <= sd;
      sync2_q <= sync1_q;
      valid_q <= 1'b0;
      if (!enable) begin
        // sample deliberately holds its last value while the channel is off.
        pcm_q  <= 1'b0;
        ovr_q  <= 1'b0;
        warm_q <= '0;
      end else begin
        pcm_q <= sync2_q;
        if (cic_done) begin
          if (warm_q == c_WARM_DONE) begin
            valid_q <= 1'b1;
            if (sat) begin
              sample_q <= {OUT_W{1'b1}};
              ovr_q    <= 1'b1;
            end else begin
              sample_q <= scaled[OUT_W-1:0];
            end
          end else begin
            warm_q <= warm_q + 2'd1;
          end
        end
      end
    end
  end

  assign pcm          = pcm_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrange    = ovr_q;

endmodule : sd_adc_decim
`default_nettype wire

// File: tb/tb_sd_adc_decim.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_sd_adc_decim                                              |
// | Purpose : Self-checking bench for sd_adc_decim. A window-convolution   |
// |           model predicts every output each cycle; directed scenarios   |
// |           pin latencies and settled sample values with literals.       |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_sd_adc_decim;

  localparam int L    = 8;
  localparam int R    = 256;
  localparam int OW   = 10;
  localparam int SH   = 3 * L - OW;
  localparam int HLEN = 3 * R - 2;
  localparam int MAXK = 16384;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sd = 1'b0;
  logic          enable;
  logic          pcm;
  logic [OW-1:0] sample;
  logic          sample_valid;
  logic          overrange;

  int total = 0;
  int bad   = 0;

  sd_adc_decim #(.DECIM_LOG2(L), .OUT_W(OW)) dut (
    .clk64M       (clk),
    .reset_n      (reset_n),
    .sd           (sd),
    .enable       (enable),
    .pcm          (pcm),
    .sample       (sample),
    .sample_valid (sample_valid),
    .overrange    (overrange)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // ---------------- sd pattern driver ----------------
  // 0: constant 0, 1: constant 1, 2: alternating, 3: 1,0,0,0
  int          pat = 0;
  logic [31:0] ph  = '0;
  always @(posedge clk) begin
    #2;
    ph = ph + 1;
    case (pat)
      0:       sd = 1'b0;
      1:       sd = 1'b1;
      2:       sd = ph[0];
      default: sd = (ph[1:0] == 2'b00);
    endcase
  end

  // ---------------- behavioural model ----------------
  // sinc3 impulse response: number of ways three offsets in [0,R) sum to j.
  longint h [HLEN];
  int     xs [MAXK];
  int     run_k = 0;
  bit     pend = 0;
  int     pend_n = 0;
  longint pend_val = 0;
  bit     started = 0;
  // Input history for the two-stage synchroniser delay.
  bit     sd_h1 = 0, sd_h2 = 0, rs_h1 = 1, rs_h2 = 1;
  int     xin;
  longint acc;
  int     kstart;
  logic          e_pcm = 0, e_valid = 0, e_ovr = 0;
  logic [OW-1:0] e_sample = '0;

  initial begin
    longint hsum;
    hsum = 0;
    for (int j = 0; j < HLEN; j++) begin
      h[j] = 0;
      for (int c = 0; c < R; c++) begin
        int a;
        a = j - c;
        if (a >= 0 && a <= 2 * R - 2)
          h[j] += (a < R) ? longint'(a + 1) : longint'(2 * R - 1 - a);
      end
      hsum += h[j];
    end
    chk("model_gain", hsum[31:0], 32'd16777216);
  end

  always @(posedge clk) begin
    started = 1;
    xin = (rs_h1 || rs_h2) ? 0 : int'(sd_h2);
    if (!reset_n) begin
      run_k = 0; pend = 0;
      e_pcm = 0; e_valid = 0; e_ovr = 0; e_sample = '0;
    end else if (!enable) begin
      run_k = 0; pend = 0;
      e_pcm = 0; e_valid = 0; e_ovr = 0;
    end else begin
      e_pcm   = xin[0];
      e_valid = 0;
      if (pend && pend_n >= 4) begin
        e_valid = 1;
        if ((pend_val >> SH) > longint'((1 << OW) - 1)) begin
          e_sample = {OW{1'b1}};
          e_ovr    = 1;
        end else begin
          e_sample = OW'(pend_val >> SH);
        end
      end
      pend = 0;
      if (run_k < MAXK) xs[run_k] = xin;
      run_k++;
      if (run_k % R == 0 && run_k <= MAXK) begin
        pend_n = run_k / R;
        kstart = run_k - 1 - (HLEN - 1);
        if (kstart < 0) kstart = 0;
        acc = 0;
        for (int k = kstart; k < run_k; k++)
          acc += longint'(xs[k]) * h[run_k - 1 - k];
        pend_val = acc;
        pend = 1;
      end
    end
    sd_h2 = sd_h1; sd_h1 = sd;
    rs_h2 = rs_h1; rs_h1 = !reset_n;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("cyc_pcm",       {31'b0, pcm},          {31'b0, e_pcm});
      chk("cyc_valid",     {31'b0, sample_valid}, {31'b0, e_valid});
      chk("cyc_sample",    {22'b0, sample},       {22'b0, e_sample});
      chk("cyc_overrange", {31'b0, overrange},    {31'b0, e_ovr});
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges until a strobe is visible, or -1.
  task automatic wait_strobe(input int maxc, output int n);
    bit got;
    int i;
    got = 0;
    i = 0;
    while (!got && i < maxc) begin
      step();
      i++;
      if (sample_valid === 1'b1) got = 1;
    end
    n = got ? i : -1;
    if (!got) chk("strobe_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    enable  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sample", {22'b0, sample}, 32'd0);
    chk("reset_valid",  {31'b0, sample_valid}, 32'd0);
    reset_n = 1'b1;

    // sd held 0: first strobe at cycle 1024, then every 256.
    wait_strobe(1100, n);
    chk("zero_first_latency", n - 1, 32'd1024);
    chk("zero_sample", {22'b0, sample}, 32'd0);
    chk("zero_ovr", {31'b0, overrange}, 32'd0);
    for (int s = 0; s < 3; s++) begin
      wait_strobe(300, n);
      chk("zero_period", n, 32'd256);
    end

    // sd held 1: pcm follows after three clocks, samples saturate.
    pat = 1;
    step(); chk("pcm_lat1", {31'b0, pcm}, 32'd0);
    step(); chk("pcm_lat2", {31'b0, pcm}, 32'd0);
    step(); chk("pcm_lat3", {31'b0, pcm}, 32'd1);
    wait_strobe(300, n);
    for (int s = 0; s < 4; s++) begin
      wait_strobe(300, n);
      chk("ones_period", n, 32'd256);
    end
    chk("ones_sample", {22'b0, sample}, 32'd1023);
    chk("ones_ovr", {31'b0, overrange}, 32'd1);

    // Enable low for 10 cycles starting at dc=100.
    repeat (99) step();
    enable = 1'b0;
    for (int s = 0; s < 10; s++) begin
      step();
      chk("gap_valid",  {31'b0, sample_valid}, 32'd0);
      chk("gap_sample", {22'b0, sample}, 32'd1023);
      chk("gap_ovr",    {31'b0, overrange}, 32'd0);
      chk("gap_pcm",    {31'b0, pcm}, 32'd0);
    end
    enable = 1'b1;
    wait_strobe(1100, n);
    chk("reen_latency", n - 1, 32'd1024);
    chk("reen_sample", {22'b0, sample}, 32'd1023);

    // Reset mid-window with sd=1.
    repeat (77) step();
    reset_n = 1'b0;
    step();
    chk("rst_pcm",    {31'b0, pcm}, 32'd0);
    chk("rst_sample", {22'b0, sample}, 32'd0);
    chk("rst_valid",  {31'b0, sample_valid}, 32'd0);
    chk("rst_ovr",    {31'b0, overrange}, 32'd0);
    reset_n = 1'b1;
    wait_strobe(1100, n);
    chk("rst_latency", n - 1, 32'd1024);
    chk("rst_sample_after", {22'b0, sample}, 32'd1023);
    chk("rst_ovr_after", {31'b0, overrange}, 32'd1);

    // Alternating pattern; a one-cycle enable drop clears overrange.
    pat = 2;
    enable = 1'b0;
    step();
    enable = 1'b1;
    wait_strobe(1100, n);
    chk("alt_latency", n - 1, 32'd1024);
    chk("alt_sample", {22'b0, sample}, 32'd512);
    chk("alt_model", {22'b0, e_sample}, 32'd512);
    chk("alt_ovr", {31'b0, overrange}, 32'd0);
    wait_strobe(300, n);
    chk("alt_sample2", {22'b0, sample}, 32'd512);

    // 1,0,0,0 pattern.
    pat = 3;
    for (int s = 0; s < 4; s++) wait_strobe(300, n);
    wait_strobe(300, n);
    chk("q_period", n, 32'd256);
    chk("q_sample", {22'b0, sample}, 32'd256);
    chk("q_ovr", {31'b0, overrange}, 32'd0);
    wait_strobe(300, n);
    chk("q_sample2", {22'b0, sample}, 32'd256);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule : tb_sd_adc_decim
`default_nettype wire
